simon_player_input: RTL and testbench

- Player-side front end of the Simon game; drives the core's player number and player press inputs.
- Converts four raw, bouncy, asynchronous push-buttons into a clean 2-bit button index plus a single-cycle press strobe.
- Presses are accepted only during the player's turn and while the game is running.
- Sits between the board button pins and the Simon core; clocked by the same 60 Hz game clock.

---
 rtl/simon_player_input.sv | 148 ++++++++++++++
 tb/tb_simon_player_input.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_player_input.sv
// simon_player_input
//   Player-side front end for the Simon core. It turns four raw, bouncy,
//   asynchronous push-buttons into a clean 2-bit button index plus a
//   one-cycle press strobe. Presses are accepted only on the player's turn
//   while the game is running. Runs on the 60 Hz game clock.
//
// Ports
//   clk            game clock (60 Hz)
//   reset          asynchronous, active-high reset
//   buttons[3:0]   raw buttons, active-high; bit i = button index i
//   simon_turn     1 while Simon plays the sequence (presses locked out)
//   game_over      1 once the game has finished (presses locked out)
//   player_num     index of the last accepted button, held until next accept
//   player_pressed one-cycle strobe; player_num is valid in the same cycle
//   button_lamp    one-hot echo of the accepted button while it is held
//   chord_error    one-cycle strobe when a multi-button chord is debounced
//
// DEBOUNCE_TICKS (1..15): consecutive equal synchronised samples needed
// before the debounced vector follows the buttons.
module simon_player_input #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       simon_turn,
  input  logic       game_over,
  output logic [1:0] player_num,
  output logic       player_pressed,
  output logic [3:0] button_lamp,
  output logic       chord_error
);

  localparam logic [3:0] TICKS  = 4'(DEBOUNCE_TICKS);
  // A button held through reset only shows up in the debounced vector
  // DEBOUNCE_TICKS+2 edges after reset; the FSM must not leave
  // WAIT_RELEASE before then or the held button would look like a press.
  localparam logic [4:0] SETTLE = 5'(DEBOUNCE_TICKS + 2);

  typedef enum logic [1:0] {WAIT_RELEASE, IDLE, HELD} state_e;

  logic [3:0] sync1_q, sync2_q, last_q;
  logic [3:0] deb_q, deb_d;
  logic [3:0] cnt_q, cnt_d, cnt_nxt;
  logic [4:0] settle_q;
  state_e     state_q;

  logic       lockout, settled, one_hot, multi;
  logic [1:0] hot_idx;

  assign lockout = simon_turn | game_over;
  assign settled = (settle_q == SETTLE);
  assign one_hot = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);
  assign multi   = (deb_q != 4'd0) && !one_hot;

  // Debounce: count how long sync2 has been stable at a value that differs
  // from the debounced vector; adopt it once the run reaches TICKS.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    cnt_nxt = 4'd1;
    if (sync2_q == deb_q) begin
      cnt_d = 4'd0;
    end else begin
      if (sync2_q == last_q) cnt_nxt = cnt_q + 4'd1;
      if (cnt_nxt == TICKS) begin
        deb_d = sync2_q;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_nxt;
      end
    end
  end

  always_comb begin
    hot_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (deb_q[i]) hot_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      last_q   <= 4'd0;
      deb_q    <= 4'd0;
      cnt_q    <= 4'd0;
      settle_q <= 5'd0;
    end else begin
      sync1_q  <= buttons;
      sync2_q  <= sync1_q;
      last_q   <= sync2_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      if (!settled) settle_q <= settle_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_RELEASE;
      player_num     <= 2'd0;
      player_pressed <= 1'b0;
      button_lamp    <= 4'd0;
      chord_error    <= 1'b0;
    end else begin
      player_pressed <= 1'b0;
      chord_error    <= 1'b0;
      case (state_q)
        WAIT_RELEASE: begin
          if (settled && deb_q == 4'd0 && !lockout) state_q <= IDLE;
        end
        IDLE: begin
          // Lockout takes priority over a press debounced in the same cycle.
          if (lockout) begin
            state_q <= WAIT_RELEASE;
          end else if (one_hot) begin
            player_num     <= hot_idx;
            button_lamp    <= deb_q;
            player_pressed <= 1'b1;
            state_q        <= HELD;
          end else if (multi) begin
            chord_error <= 1'b1;
            state_q     <= WAIT_RELEASE;
          end
        end
        HELD: begin
          if (lockout) begin
            button_lamp <= 4'd0;
            state_q     <= WAIT_RELEASE;
          end else if (deb_q == 4'd0) begin
            button_lamp <= 4'd0;
            state_q     <= IDLE;
          end else if ((deb_q & button_lamp) == 4'd0) begin
            // Held button dropped while another came in on the same update:
            // count it as a release only; the new one must be re-pressed.
            button_lamp <= 4'd0;
            state_q     <= WAIT_RELEASE;
          end
          // Otherwise the held button is still down; extra buttons ignored.
        end
        default: state_q <= WAIT_RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_player_input.sv
module tb_simon_player_input;

  localparam int T = 3;
  localparam int M_WAIT = 0, M_READY = 1, M_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'd0;
  logic       simon_turn = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] player_num;
  logic       player_pressed;
  logic [3:0] button_lamp;
  logic       chord_error;

  simon_player_input #(.DEBOUNCE_TICKS(T)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .simon_turn(simon_turn),
    .game_over(game_over), .player_num(player_num),
    .player_pressed(player_pressed), .button_lamp(button_lamp),
    .chord_error(chord_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: raw-sample history, "last T samples agree" debounce,
  // and a player-mode tracker driven by the behavioural rules.
  logic [3:0] hist[$];
  logic [3:0] m_deb;
  int         m_mode;
  int         m_edges;
  logic       e_pressed, e_chord;
  logic [1:0] e_num;
  logic [3:0] e_lamp;

  int         strobes, chords;
  logic       prev_pressed;
  logic [1:0] nums_seen[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < T + 2; i++) hist.push_back(4'd0);
    m_deb = 4'd0; m_mode = M_WAIT; m_edges = 0;
    e_pressed = 1'b0; e_chord = 1'b0; e_num = 2'd0; e_lamp = 4'd0;
    prev_pressed = 1'b0;
  endtask

  task automatic model_edge();
    logic       lock;
    logic [3:0] d;
    bit         stable;
    m_edges++;
    lock = simon_turn | game_over;
    d = m_deb;
    hist.push_front(buttons);
    void'(hist.pop_back());
    e_pressed = 1'b0;
    e_chord = 1'b0;
    if (m_mode == M_WAIT) begin
      // a button held through reset reaches the debounced vector at edge T+2
      if (m_edges >= T + 3 && d == 4'd0 && !lock) m_mode = M_READY;
    end else if (m_mode == M_READY) begin
      if (lock) m_mode = M_WAIT;
      else if ($countones(d) == 1) begin
        e_pressed = 1'b1;
        e_lamp = d;
        for (int b = 0; b < 4; b++) if (d[b]) e_num = 2'(b);
        m_mode = M_HOLD;
      end else if ($countones(d) >= 2) begin
        e_chord = 1'b1;
        m_mode = M_WAIT;
      end
    end else begin
      if (lock) begin e_lamp = 4'd0; m_mode = M_WAIT; end
      else if (d == 4'd0) begin e_lamp = 4'd0; m_mode = M_READY; end
      else if ((d & e_lamp) == 4'd0) begin e_lamp = 4'd0; m_mode = M_WAIT; end
    end
    // synchronised samples used at this edge are raw samples 2..T+1 back
    stable = 1;
    for (int i = 3; i <= T + 1; i++) if (hist[i] != hist[2]) stable = 0;
    if (stable && hist[2] != m_deb) m_deb = hist[2];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("pressed", {7'd0, player_pressed}, {7'd0, e_pressed});
    check("num", {6'd0, player_num}, {6'd0, e_num});
    check("lamp", {4'd0, button_lamp}, {4'd0, e_lamp});
    check("chord", {7'd0, chord_error}, {7'd0, e_chord});
    check("spacing", {7'd0, player_pressed & prev_pressed}, 8'd0);
    prev_pressed = player_pressed;
    if (player_pressed) begin strobes++; nums_seen.push_back(player_num); end
    if (chord_error) chords++;
  endtask

  task automatic run(input logic [3:0] b, input int n);
    buttons = b;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check("rst_num", {6'd0, player_num}, 8'd0);
    check("rst_pressed", {7'd0, player_pressed}, 8'd0);
    check("rst_lamp", {4'd0, button_lamp}, 8'd0);
    check("rst_chord", {7'd0, chord_error}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int first_at;
    logic [3:0] v;
    model_reset();
    strobes = 0; chords = 0;
    do_reset();
    run(4'b0000, 10);

    // single press: latency, index, lamp lifetime
    strobes = 0; first_at = 0;
    buttons = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (player_pressed && first_at == 0) first_at = i;
      if (i == 6) begin
        check("t1_num", {6'd0, player_num}, 8'd2);
        check("t1_lamp", {4'd0, button_lamp}, 8'h04);
      end
    end
    check("t1_latency", 8'(first_at), 8'd6);
    check("t1_count", 8'(strobes), 8'd1);
    buttons = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) check("t1_lamp_hold", {4'd0, button_lamp}, 8'h04);
      if (i == 6) check("t1_lamp_off", {4'd0, button_lamp}, 8'h00);
    end
    run(4'b0000, 4);

    // bounce on button 1
    strobes = 0; chords = 0;
    for (int i = 0; i < 8; i++) run((i % 2 == 0) ? 4'b0010 : 4'b0000, 1);
    run(4'b0000, 8);
    check("t2_strobes", 8'(strobes), 8'd0);
    check("t2_chords", 8'(chords), 8'd0);
    check("t2_deb_lamp", {4'd0, button_lamp}, 8'd0);

    // press during Simon's turn, held across the end of the turn
    strobes = 0;
    simon_turn = 1'b1;
    run(4'b0001, 10);
    simon_turn = 1'b0;
    run(4'b0001, 10);
    check("t3_locked", 8'(strobes), 8'd0);
    run(4'b0000, 8);
    run(4'b0001, 10);
    check("t3_count", 8'(strobes), 8'd1);
    check("t3_num", {6'd0, player_num}, 8'd0);
    run(4'b0000, 8);

    // chord then clean press
    strobes = 0; chords = 0;
    run(4'b0011, 10);
    check("t4_chord", 8'(chords), 8'd1);
    check("t4_nopress", 8'(strobes), 8'd0);
    run(4'b0000, 8);
    run(4'b1000, 10);
    check("t4_count", 8'(strobes), 8'd1);
    check("t4_num", {6'd0, player_num}, 8'd3);
    run(4'b0000, 8);

    // reset while a button is held
    run(4'b1000, 5);
    do_reset();
    strobes = 0;
    run(4'b1000, 20);
    check("t5_noglitch", 8'(strobes), 8'd0);
    run(4'b0000, 8);
    run(4'b1000, 10);
    check("t5_count", 8'(strobes), 8'd1);
    check("t5_num", {6'd0, player_num}, 8'd3);
    run(4'b0000, 8);

    // three quick presses
    strobes = 0; nums_seen = {};
    for (int k = 0; k < 3; k++) begin
      v = 4'b0001 << k;
      run(v, 8);
      run(4'b0000, 8);
    end
    check("t6_count", 8'(strobes), 8'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("t6_num%0d", k),
            {6'd0, (k < nums_seen.size()) ? nums_seen[k] : 2'd3}, 8'(k));

    // randomized segments against the model
    for (int s = 0; s < 300; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) v = 4'b0000;
      else if (r < 8) v = 4'b0001 << $urandom_range(0, 3);
      else v = 4'($urandom_range(0, 15));
      simon_turn = ($urandom_range(0, 7) == 0);
      game_over  = ($urandom_range(0, 15) == 0);
      run(v, $urandom_range(1, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
